bcd_calc_engine: RTL
====================

// Module: bcd_calc_engine
// PURPOSE
// Parametrised successor of the fixed 12-bit add-and-display chain. Takes decimal operands A and B
// keyed in one BCD digit at a time, then computes A+B or A-B (sign + magnitude). Converts the
// binary result to BCD with a sequential double-dabble (one shift per cycle). Drives OUT_DIGITS BCD
// digits to the 7-seg decoder, with a start/busy/done handshake and an overflow flag.
// PARAMETERS
// IN_DIGITS   3   max decimal digits per operand; operand max = 10**IN_DIGITS-1
// OUT_DIGITS  4   BCD digits driven on bcd_out
// (localparam) OP_W  = $clog2(10**IN_DIGITS)            binary operand width (3 -> 10)
// (localparam) RES_W = $clog2(2*(10**IN_DIGITS-1)+1)    binary result width  (3 -> 11)
// PORTS
// clk          in   1              system clock, all logic on rising edge
// rst          in   1              synchronous, active-high reset
// clear        in   1              1-cycle pulse: drop operands, return to ENTRY_A
// digit_valid  in   1              1-cycle pulse: digit_in is a keyed digit
// digit_in     in   4              BCD digit; values 10..15 are ignored
// enter        in   1              1-cycle pulse: commit operand A
// op_sub       in   1              0 = add, 1 = subtract; sampled only in COMPUTE
// start        in   1              1-cycle pulse: begin computation (ENTRY_B only)
// busy         out  1              high in COMPUTE and CONVERT
// done         out  1              1-cycle pulse on entry to SHOW
// bcd_out      out  4*OUT_DIGITS   digit k at [4k+3:4k], k=0 is units
// negative     out  1              result < 0 (valid in SHOW)
// overflow     out  1              |result| > 10**OUT_DIGITS-1 (valid in SHOW)
// BEHAVIOUR
// - Reset: state=ENTRY_A; op_a, op_b, digit count and bcd_out = 0; busy, done, negative, overflow = 0.
// - Priority each cycle: rst > clear > start > enter > digit_valid.
// - clear (any state): same as reset, next cycle. Also aborts COMPUTE/CONVERT; done is not pulsed.
// - ENTRY_A: a valid digit (<=9) with count<IN_DIGITS does op_a <= op_a*10 + digit, count++.
//   Extra digits and digits >9 are ignored. bcd_out echoes op_a, zero-padded, updated the cycle
//   after the digit. enter -> ENTRY_B, count=0, bcd_out=0. start is ignored.
// - ENTRY_B: same digit rules on op_b; enter is ignored. start -> COMPUTE. A digit in the same
//   cycle as start is dropped.
// - COMPUTE (1 cycle): sample op_sub. Add: res=op_a+op_b, negative=0. Sub: negative=(op_b>op_a),
//   res=|op_a-op_b|. res is RES_W bits; no binary overflow is possible. -> CONVERT.
// - CONVERT: RES_W iterations of double dabble, one per cycle: add 3 to each nibble >=5, then
//   shift left one bit. Scratch is 4*OUT_DIGITS+RES_W bits. bcd_out holds the op_b echo meanwhile.
//   After the last iteration -> SHOW.
// - SHOW: on entry, done=1 for exactly one cycle and bcd_out is loaded with the result.
//   If res > 10**OUT_DIGITS-1: overflow=1 and every bcd_out digit = 9 (saturate).
//   bcd_out, negative and overflow are held until clear, enter or rst.
//   enter in SHOW acts as clear. digit_valid and start in SHOW are ignored.
// - Latency: start sampled at edge k; done high in the cycle after edge k+RES_W+1
//   (defaults: 12 edges after start, i.e. 13th cycle).
// - busy=0 whenever done=1. negative and overflow clear on leaving SHOW.
// - Elaboration check: OUT_DIGITS >= 1 and IN_DIGITS >= 1, else $error.
// TESTING
// 1 Keys 1,2,3, enter, 4,5,6, start, op_sub=0 -> done 12 edges after start; bcd_out=16'h0579,
//   negative=0, overflow=0.
// 2 A=25, B=100, op_sub=1 -> bcd_out=16'h0075, negative=1. A=B=999 sub -> 16'h0000, negative=0.
// 3 A=999, B=999 add -> 16'h1998. Repeat with OUT_DIGITS=3 -> bcd_out=12'h999, overflow=1.
// 4 Keys 1,2,3,4 and digit 4'hC in ENTRY_A -> echo stays 16'h0123. start before enter -> no busy.
// 5 clear pulsed on cycle 5 of CONVERT -> busy falls next cycle, no done, bcd_out=0, state ENTRY_A.
//   rst mid-CONVERT behaves the same.
// 6 ENTRY_B with start+digit_valid in one cycle -> digit dropped. In SHOW, enter -> ENTRY_A with
//   bcd_out=0; a new A is then accepted.

Source files
------------

// File: rtl/bcd_calc_engine_if.sv
// Handshake/bus bundle for bcd_calc_engine.
// master: keypad/controller side, drives clear, digit_valid, digit_in, enter, op_sub, start.
// slave : engine side, drives busy, done, bcd_out, negative, overflow.
// bcd_out carries OUT_DIGITS BCD digits, digit k at [4k+3:4k], k=0 is units.
interface bcd_calc_engine_if #(
    parameter int unsigned OUT_DIGITS = 4
);
    logic                    clear;
    logic                    digit_valid;
    logic [3:0]              digit_in;
    logic                    enter;
    logic                    op_sub;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic [4*OUT_DIGITS-1:0] bcd_out;
    logic                    negative;
    logic                    overflow;

    modport master (
        output clear, digit_valid, digit_in, enter, op_sub, start,
        input  busy, done, bcd_out, negative, overflow
    );

    modport slave (
        input  clear, digit_valid, digit_in, enter, op_sub, start,
        output busy, done, bcd_out, negative, overflow
    );
endinterface

// File: rtl/bcd_calc_engine.sv
// Decimal keypad calculator core: operands A and B are keyed one BCD digit at a time, then
// A+B or A-B (sign + magnitude) is computed and converted to BCD by a sequential double
// dabble (one shift per cycle). Results above the display range saturate to all nines.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of bcd_calc_engine_if (keypad controls in, busy/done/display out)
module bcd_calc_engine #(
    parameter int unsigned IN_DIGITS  = 3,
    parameter int unsigned OUT_DIGITS = 4
) (
    input logic              clk,
    input logic              rst,
    bcd_calc_engine_if.slave bus
);
    localparam int unsigned OP_W    = $clog2(10 ** IN_DIGITS);
    localparam int unsigned RES_W   = $clog2(2 * (10 ** IN_DIGITS - 1) + 1);
    localparam int unsigned BCD_W   = 4 * OUT_DIGITS;
    localparam int unsigned SCR_W   = BCD_W + RES_W;
    localparam int unsigned CNT_W   = $clog2(IN_DIGITS + 1);
    localparam int unsigned ITER_W  = $clog2(RES_W + 1);
    localparam int unsigned OUT_MAX = 10 ** OUT_DIGITS - 1;

    localparam logic [CNT_W-1:0]  CntMax   = CNT_W'(IN_DIGITS);
    localparam logic [ITER_W-1:0] IterLast = ITER_W'(RES_W - 1);

    localparam logic [2:0] StEntryA  = 3'd0;
    localparam logic [2:0] StEntryB  = 3'd1;
    localparam logic [2:0] StCompute = 3'd2;
    localparam logic [2:0] StConvert = 3'd3;
    localparam logic [2:0] StShow    = 3'd4;

    if (OUT_DIGITS == 0 || IN_DIGITS == 0) begin : gen_param_check
        $error("bcd_calc_engine: IN_DIGITS and OUT_DIGITS must both be >= 1");
    end

    function automatic logic [BCD_W-1:0] all_nines();
        logic [BCD_W-1:0] v;
        v = '0;
        for (int k = 0; k < int'(OUT_DIGITS); k++) begin
            v[4*k +: 4] = 4'd9;
        end
        return v;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [OP_W-1:0]   op_a_q, op_a_d;
    logic [OP_W-1:0]   op_b_q, op_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [SCR_W-1:0]  scr_q, scr_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic              digit_ok;
    logic              go_idle;
    logic [OP_W-1:0]   op_cur;
    logic [OP_W-1:0]   op_next;
    logic [BCD_W-1:0]  bcd_shifted;
    logic [RES_W-1:0]  a_ext, b_ext;
    logic [SCR_W-1:0]  scr_step;

    assign digit_ok = bus.digit_valid && (bus.digit_in <= 4'd9) && (cnt_q < CntMax);

    // One accumulator path shared by both entry states.
    assign op_cur      = (state_q == StEntryB) ? op_b_q : op_a_q;
    assign op_next     = OP_W'(op_cur * OP_W'(10)) + OP_W'(bus.digit_in);
    // The display echo is just the keyed digits shifted in, so no binary-to-BCD is needed here.
    assign bcd_shifted = (bcd_q << 4) | BCD_W'(bus.digit_in);

    assign a_ext = RES_W'(op_a_q);
    assign b_ext = RES_W'(op_b_q);

    // One double-dabble iteration: +3 on every BCD nibble >= 5, then shift left.
    always_comb begin
        scr_step = scr_q;
        for (int k = 0; k < int'(OUT_DIGITS); k++) begin
            if (scr_step[RES_W + 4*k +: 4] >= 4'd5) begin
                scr_step[RES_W + 4*k +: 4] = scr_step[RES_W + 4*k +: 4] + 4'd3;
            end
        end
        scr_step = scr_step << 1;
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        scr_d   = scr_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        go_idle = 1'b0;

        case (state_q)
            StEntryA: begin
                if (bus.enter) begin
                    state_d = StEntryB;
                    cnt_d   = '0;
                    bcd_d   = '0;
                end else if (digit_ok) begin
                    op_a_d = op_next;
                    cnt_d  = cnt_q + CNT_W'(1);
                    bcd_d  = bcd_shifted;
                end
            end
            StEntryB: begin
                // start wins over a digit keyed in the same cycle.
                if (bus.start) begin
                    state_d = StCompute;
                end else if (digit_ok) begin
                    op_b_d = op_next;
                    cnt_d  = cnt_q + CNT_W'(1);
                    bcd_d  = bcd_shifted;
                end
            end
            StCompute: begin
                if (bus.op_sub) begin
                    if (op_b_q > op_a_q) begin
                        neg_d = 1'b1;
                        res_d = b_ext - a_ext;
                    end else begin
                        neg_d = 1'b0;
                        res_d = a_ext - b_ext;
                    end
                end else begin
                    neg_d = 1'b0;
                    res_d = a_ext + b_ext;
                end
                scr_d   = {{BCD_W{1'b0}}, res_d};
                iter_d  = '0;
                state_d = StConvert;
            end
            StConvert: begin
                scr_d  = scr_step;
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == IterLast) begin
                    state_d = StShow;
                    done_d  = 1'b1;
                    // Saturate on the binary value; the BCD field may have lost high digits.
                    if (32'(res_q) > OUT_MAX) begin
                        ovf_d = 1'b1;
                        bcd_d = all_nines();
                    end else begin
                        bcd_d = scr_step[SCR_W-1 -: BCD_W];
                    end
                end
            end
            StShow: begin
                if (bus.enter) begin
                    go_idle = 1'b1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (bus.clear || go_idle) begin
            state_d = StEntryA;
            op_a_d  = '0;
            op_b_d  = '0;
            cnt_d   = '0;
            bcd_d   = '0;
            neg_d   = 1'b0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEntryA;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            scr_q   <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            scr_q   <= scr_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q == StCompute) || (state_q == StConvert);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.negative = neg_q;
    assign bus.overflow = ovf_q;
endmodule
